// File: rtl/alu_pkg.sv
// alu_pkg: opcode and ALU control codes shared by the issue stage and the ALU
package alu_pkg;
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SLTI = 4'b0100;
  localparam logic [3:0] OP_SLLI = 4'b0101;
  localparam logic [3:0] OP_SRLI = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b001;
  localparam logic [2:0] ALU_CTRL_NOT = 3'b010;
  localparam logic [2:0] ALU_CTRL_SLL = 3'b011;
  localparam logic [2:0] ALU_CTRL_SRL = 3'b100;
  localparam logic [2:0] ALU_CTRL_AND = 3'b101;
  localparam logic [2:0] ALU_CTRL_OR  = 3'b110;
  localparam logic [2:0] ALU_CTRL_SLT = 3'b111;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: instruction -> ALU control, immediate, destination and branch/illegal flags
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic [15:0]           instr,
  output logic [2:0]            ctrl,
  output logic                  use_imm,
  output logic [DATA_W-1:0]     imm,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  branch,
  output logic                  bne,
  output logic                  illegal
);
  logic [3:0] op;
  logic       unused_rs;
  assign op        = instr[15:12];
  assign unused_rs = ^instr[11:9];
  // Table decode; immediate ops default to zero-extended imm6 and rt as destination
  always_comb begin
    ctrl    = ALU_CTRL_ADD;
    use_imm = 1'b1;
    imm     = {{(DATA_W-6){1'b0}}, instr[5:0]};
    wr_en   = 1'b1;
    dest    = instr[6 +: REG_ADDR_W];
    branch  = 1'b0;
    bne     = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        ctrl    = instr[2:0];
        use_imm = 1'b0;
        dest    = instr[3 +: REG_ADDR_W];
      end
      OP_ADDI: imm = {{(DATA_W-6){instr[5]}}, instr[5:0]};
      OP_ANDI: ctrl = ALU_CTRL_AND;
      OP_ORI:  ctrl = ALU_CTRL_OR;
      OP_SLTI: begin
        ctrl = ALU_CTRL_SLT;
        imm  = {{(DATA_W-6){instr[5]}}, instr[5:0]};
      end
      OP_SLLI: begin
        ctrl = ALU_CTRL_SLL;
        imm  = {{(DATA_W-4){1'b0}}, instr[3:0]};
      end
      OP_SRLI: begin
        ctrl = ALU_CTRL_SRL;
        imm  = {{(DATA_W-4){1'b0}}, instr[3:0]};
      end
      OP_BEQ, OP_BNE: begin
        ctrl    = ALU_CTRL_SUB;
        use_imm = 1'b0;
        wr_en   = 1'b0;
        branch  = 1'b1;
        bne     = (op == OP_BNE);
      end
      default: begin
        use_imm = 1'b0;
        wr_en   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue (E) stage driving the ALU and result (R) stage capturing it
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           instr,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic                  flush,
  output logic [DATA_W-1:0]     alu_in1,
  output logic [DATA_W-1:0]     alu_in2,
  output logic [2:0]            alu_control,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_zero,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic                  res_wr_en,
  output logic [REG_ADDR_W-1:0] res_wr_addr,
  output logic                  res_branch,
  output logic                  res_taken,
  output logic                  res_illegal
);
  logic                  e_valid, e_wr_en, e_branch, e_bne, e_illegal;
  logic [REG_ADDR_W-1:0] e_dest;
  logic [2:0]            d_ctrl;
  logic                  d_use_imm, d_wr_en, d_branch, d_bne, d_illegal;
  logic [DATA_W-1:0]     d_imm;
  logic [REG_ADDR_W-1:0] d_dest;
  logic                  r_adv, accept, move;

  alu_op_decode #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_dec (
    .instr   (instr),
    .ctrl    (d_ctrl),
    .use_imm (d_use_imm),
    .imm     (d_imm),
    .wr_en   (d_wr_en),
    .dest    (d_dest),
    .branch  (d_branch),
    .bne     (d_bne),
    .illegal (d_illegal)
  );

  // Handshake: R frees when empty or drained; flush blocks acceptance and stops the E->R move
  always_comb begin
    r_adv    = ~res_valid | res_ready;
    in_ready = ~flush & (~e_valid | r_adv);
    accept   = in_valid & in_ready;
    move     = e_valid & r_adv & ~flush;
  end

  // E stage: operands and sideband load only on accept, so the ALU inputs stay stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid     <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_control <= ALU_CTRL_ADD;
      e_wr_en     <= 1'b0;
      e_dest      <= '0;
      e_branch    <= 1'b0;
      e_bne       <= 1'b0;
      e_illegal   <= 1'b0;
    end else begin
      e_valid <= accept | (e_valid & ~r_adv & ~flush);
      if (accept) begin
        alu_in1     <= rs_data;
        alu_in2     <= d_use_imm ? d_imm : rt_data;
        alu_control <= d_ctrl;
        e_wr_en     <= d_wr_en;
        e_dest      <= d_dest;
        e_branch    <= d_branch;
        e_bne       <= d_bne;
        e_illegal   <= d_illegal;
      end
    end
  end

  // R stage: capture the ALU's combinational result when the E entry advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_branch  <= 1'b0;
      res_taken   <= 1'b0;
      res_illegal <= 1'b0;
    end else if (move) begin
      res_valid   <= 1'b1;
      res_data    <= alu_out;
      res_wr_en   <= e_wr_en;
      res_wr_addr <= e_dest;
      res_branch  <= e_branch;
      res_taken   <= e_branch & (alu_zero ^ e_bne);
      res_illegal <= e_illegal;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of the issue/result stages against a queue model
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, res_ready = 1'b1;
  logic [15:0] instr = '0, rs_data = '0, rt_data = '0;
  logic        in_ready, alu_zero, res_valid, res_wr_en, res_branch, res_taken, res_illegal;
  logic [15:0] alu_in1, alu_in2, alu_out, res_data;
  logic [2:0]  alu_control, res_wr_addr;

  typedef struct packed {
    logic [15:0] data, in1, in2;
    logic [2:0]  ctrl, addr;
    logic        wr, br, tk, ill, cd, ci;
  } exp_t;

  exp_t q[$];
  logic m_e = 1'b0, m_r = 1'b0, exp_rdy, seen_rdy;
  int   checks = 0, failures = 0;

  alu_issue_stage #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_control(alu_control), .alu_out(alu_out), .alu_zero(alu_zero), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
    .res_branch(res_branch), .res_taken(res_taken), .res_illegal(res_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(logic [2:0] c, logic [15:0] a, logic [15:0] b);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ~a;
      3'd3: return (b >= 16) ? 16'd0 : a << b[3:0];
      3'd4: return (b >= 16) ? 16'd0 : a >> b[3:0];
      3'd5: return a & b;
      3'd6: return a | b;
      default: return (a < b) ? 16'd1 : 16'd0;
    endcase
  endfunction

  // Behavioural ALU standing in for the real one
  always_comb begin
    alu_out  = alu_fn(alu_control, alu_in1, alu_in2);
    alu_zero = (alu_out == 16'd0);
  end

  function automatic exp_t ref_fn(logic [15:0] i, logic [15:0] a, logic [15:0] b);
    exp_t e;
    logic [15:0] se, ze, sh;
    se = {{10{i[5]}}, i[5:0]};
    ze = {10'd0, i[5:0]};
    sh = {12'd0, i[3:0]};
    e = '0;
    e.in1 = a; e.addr = i[8:6]; e.wr = 1'b1; e.cd = 1'b1; e.ci = 1'b1;
    case (i[15:12])
      4'd0: begin e.ctrl = i[2:0]; e.in2 = b; e.addr = i[5:3]; e.data = alu_fn(i[2:0], a, b); end
      4'd1: begin e.ctrl = 3'd0; e.in2 = se; e.data = a + se; end
      4'd2: begin e.ctrl = 3'd5; e.in2 = ze; e.data = a & ze; end
      4'd3: begin e.ctrl = 3'd6; e.in2 = ze; e.data = a | ze; end
      4'd4: begin e.ctrl = 3'd7; e.in2 = se; e.data = (a < se) ? 16'd1 : 16'd0; end
      4'd5: begin e.ctrl = 3'd3; e.in2 = sh; e.data = a << i[3:0]; end
      4'd6: begin e.ctrl = 3'd4; e.in2 = sh; e.data = a >> i[3:0]; end
      4'd7, 4'd8: begin
        e.ctrl = 3'd1; e.in2 = b; e.data = a - b; e.wr = 1'b0; e.br = 1'b1;
        e.tk = (i[15:12] == 4'd7) == (a == b);
      end
      default: begin e.wr = 1'b0; e.ill = 1'b1; e.cd = 1'b0; e.ci = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic tick();
    logic adv, rdy, acc, kill, mv;
    exp_t n;
    @(negedge clk);
    adv = !m_r || res_ready;
    rdy = !flush && (!m_e || adv);
    acc = in_valid && rdy;
    kill = m_e && flush;
    mv = m_e && adv && !flush;
    exp_rdy = rdy;
    seen_rdy = in_ready;
    n = ref_fn(instr, rs_data, rt_data);
    @(posedge clk);
    #1;
    if (kill) void'(q.pop_back());
    if (m_r && res_ready) void'(q.pop_front());
    if (acc) q.push_back(n);
    m_e = acc || (m_e && !adv && !flush);
    m_r = mv || (m_r && !res_ready);
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (res_valid !== 1'b0 || alu_in1 !== 16'd0 || alu_in2 !== 16'd0 || alu_control !== 3'd0 ||
        res_data !== 16'd0 || res_wr_en !== 1'b0 || res_taken !== 1'b0 || res_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset: res_valid=%b in1=%h in2=%h ctrl=%h res_data=%h expected all zero",
               res_valid, alu_in1, alu_in2, alu_control, res_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    instr = {4'h1, 3'd1, 3'd2, 6'h3F}; rs_data = 16'd5; rt_data = 16'h7777; in_valid = 1'b1;
    tick();
    checks++;
    if (alu_in2 !== 16'hFFFF || alu_in1 !== 16'd5 || alu_control !== 3'd0) begin
      failures++;
      $display("FAIL addi_issue: in1=%h in2=%h ctrl=%h expected 0005 ffff 0", alu_in1, alu_in2, alu_control);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'd4 || res_wr_addr !== 3'd2 || res_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL addi_result: valid=%b data=%h addr=%0d wr=%b expected 1 0004 2 1",
               res_valid, res_data, res_wr_addr, res_wr_en);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rs_data = 16'd7; rt_data = 16'd7; in_valid = 1'b1;
    instr = {4'h0, 3'd1, 3'd2, 3'd3, 3'b001};
    tick();
    instr = {4'h7, 3'd1, 3'd2, 6'd0};
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'd0 || res_wr_addr !== 3'd3 || res_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL sub_result: valid=%b data=%h addr=%0d wr=%b expected 1 0000 3 1",
               res_valid, res_data, res_wr_addr, res_wr_en);
    end
    instr = {4'h8, 3'd1, 3'd2, 6'd0};
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_branch !== 1'b1 || res_taken !== 1'b1 || res_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL beq_taken: valid=%b br=%b taken=%b wr=%b expected 1 1 1 0",
               res_valid, res_branch, res_taken, res_wr_en);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_branch !== 1'b1 || res_taken !== 1'b0) begin
      failures++;
      $display("FAIL bne_not_taken: valid=%b br=%b taken=%b expected 1 1 0", res_valid, res_branch, res_taken);
    end
    tick();
  endtask

  task automatic test_slli();
    instr = {4'h5, 3'd1, 3'd2, 6'h3F}; rs_data = 16'h0001; in_valid = 1'b1;
    tick();
    checks++;
    if (alu_in2 !== 16'd15 || alu_control !== 3'd3) begin
      failures++;
      $display("FAIL slli_issue: in2=%h ctrl=%h expected 000f 3", alu_in2, alu_control);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (res_data !== 16'h8000 || res_valid !== 1'b1) begin
      failures++;
      $display("FAIL slli_result: data=%h valid=%b expected 8000 1", res_data, res_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    int k = 0;
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      instr = {4'h1, 3'd0, 3'd4, 6'd1}; rs_data = 16'd100 + 16'(k); in_valid = 1'b1;
      tick();
      if (seen_rdy) k++;
    end
    checks++;
    if (k != 2 || in_ready !== 1'b0 || res_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: accepted=%0d in_ready=%b res_valid=%b expected 2 0 1", k, in_ready, res_valid);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      if (res_valid) got.push_back(res_data);
      in_valid = (k < 3);
      rs_data = 16'd100 + 16'(k);
      tick();
      if (in_valid && seen_rdy) k++;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL bp_count: results=%0d expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 16'd101 + 16'(i)) begin
          failures++;
          $display("FAIL bp_order[%0d]: data=%h expected %h", i, got[i], 16'd101 + 16'(i));
        end
      end
    end
    drain();
  endtask

  task automatic test_flush();
    instr = {4'h2, 3'd0, 3'd1, 6'h0F}; rs_data = 16'h1234; in_valid = 1'b1;
    tick();
    instr = {4'h3, 3'd0, 3'd1, 6'h01}; rs_data = 16'h0100; flush = 1'b1;
    tick();
    checks++;
    if (seen_rdy !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: in_ready=%b expected 0", seen_rdy);
    end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_kill: res_valid=%b data=%h expected 0", res_valid, res_data);
    end
    in_valid = 1'b1;
    tick();
    checks++;
    if (seen_rdy !== 1'b1) begin
      failures++;
      $display("FAIL flush_next_accept: in_ready=%b expected 1", seen_rdy);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0101) begin
      failures++;
      $display("FAIL flush_next_result: valid=%b data=%h expected 1 0101", res_valid, res_data);
    end
    tick();
  endtask

  task automatic test_illegal();
    instr = 16'hF1C7; rs_data = 16'h0042; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_illegal !== 1'b1 || res_wr_en !== 1'b0 || res_branch !== 1'b0) begin
      failures++;
      $display("FAIL illegal: valid=%b ill=%b wr=%b br=%b expected 1 1 0 0",
               res_valid, res_illegal, res_wr_en, res_branch);
    end
    tick();
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0; in_valid = 1'b1; rs_data = 16'h5555; rt_data = 16'h0003;
    instr = {4'h0, 3'd1, 3'd2, 3'd3, 3'b110};
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || alu_in1 !== 16'd0 || alu_in2 !== 16'd0 || alu_control !== 3'd0 ||
        res_data !== 16'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: valid=%b in1=%h in2=%h ctrl=%h data=%h in_ready=%b expected 0 0 0 0 0 1",
               res_valid, alu_in1, alu_in2, alu_control, res_data, in_ready);
    end
    q.delete(); m_e = 1'b0; m_r = 1'b0;
    in_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_after: res_valid=%b expected 0", res_valid);
    end
  endtask

  task automatic test_random();
    exp_t h;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      instr = 16'($urandom);
      rs_data = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      rt_data = ($urandom_range(0, 2) == 0) ? rs_data :
                ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      tick();
      checks++;
      if (seen_rdy !== exp_rdy) begin
        failures++;
        $display("FAIL rand_in_ready@%0d: got=%b expected=%b", c, seen_rdy, exp_rdy);
      end
      checks++;
      if (res_valid !== m_r) begin
        failures++;
        $display("FAIL rand_res_valid@%0d: got=%b expected=%b", c, res_valid, m_r);
      end
      if (m_r) begin
        h = q[0];
        checks++;
        if ((h.cd && res_data !== h.data) || res_wr_en !== h.wr || (h.wr && res_wr_addr !== h.addr) ||
            res_branch !== h.br || res_taken !== h.tk || res_illegal !== h.ill) begin
          failures++;
          $display("FAIL rand_result@%0d: data=%h wr=%b addr=%0d br=%b tk=%b ill=%b expected %h %b %0d %b %b %b",
                   c, res_data, res_wr_en, res_wr_addr, res_branch, res_taken, res_illegal,
                   h.data, h.wr, h.addr, h.br, h.tk, h.ill);
        end
      end
      if (m_e) begin
        h = q[$];
        checks++;
        if (alu_in1 !== h.in1 || alu_control !== h.ctrl || (h.ci && alu_in2 !== h.in2)) begin
          failures++;
          $display("FAIL rand_issue@%0d: in1=%h in2=%h ctrl=%h expected %h %h %h",
                   c, alu_in1, alu_in2, alu_control, h.in1, h.in2, h.ctrl);
        end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_slli();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
